core_lsu: RTL and testbench

CORE_LSU -- requirements
Module: core_lsu

---
 rtl/core_lsu_if.sv | 33 +++
 rtl/core_lsu.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_core_lsu.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_lsu_if.sv
// -----------------------------------------------------------------------------
// core_lsu_if -- word-oriented memory bus between the load/store unit and the
// data memory.
//
//   mem_req    LSU -> mem  request, held high until mem_ack
//   mem_we     LSU -> mem  1 = write, 0 = read
//   mem_addr   LSU -> mem  word-aligned address
//   mem_be     LSU -> mem  byte enables, bit n selects byte lane n
//   mem_wdata  LSU -> mem  lane-replicated store data
//   mem_ack    mem -> LSU  completion; mem_rdata is valid in the same cycle
//   mem_rdata  mem -> LSU  read word
//
// The master modport is the LSU side; the slave modport is the memory side.
// -----------------------------------------------------------------------------
interface core_lsu_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/core_lsu.sv
// -----------------------------------------------------------------------------
// core_lsu -- single-access load/store unit.
//
// A one-cycle start pulse captures the effective address, store data and the
// decoder's op flags. Aligned accesses are issued as one word-wide request on
// the memory bus; misaligned accesses (and a start with no op flag) skip the bus
// and finish immediately. Loads pick their byte/halfword lane out of the read
// word, extend it and hold it on load_data until the next completed load.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   start             one-cycle request pulse (ignored while busy)
//   i_lb .. i_lhu     load op flags
//   i_sb, i_sh, i_sw  store op flags
//   addr              effective address (rs1 + imm)
//   wdata             store data (rs2)
//   bus               memory bus, master side
//   busy              high from the cycle after start until done inclusive
//   done              one-cycle completion pulse
//   load_data         extended load result
//   misalign          one-cycle pulse with done for a misaligned access
//
// Timing: start in cycle 0 -> mem_req in cycle 1 -> done one cycle after the
// mem_ack cycle. A misaligned access gives done/misalign in cycle 1.
// -----------------------------------------------------------------------------
module core_lsu (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              i_lb,
  input  logic              i_lh,
  input  logic              i_lw,
  input  logic              i_lbu,
  input  logic              i_lhu,
  input  logic              i_sb,
  input  logic              i_sh,
  input  logic              i_sw,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  core_lsu_if.master        bus,
  output logic              busy,
  output logic              done,
  output logic [31:0]       load_data,
  output logic              misalign
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LB   = 4'd1,
    OP_LH   = 4'd2,
    OP_LW   = 4'd3,
    OP_LBU  = 4'd4,
    OP_LHU  = 4'd5,
    OP_SB   = 4'd6,
    OP_SH   = 4'd7,
    OP_SW   = 4'd8
  } op_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e      state_q,     state_d;
  op_e         op_q,        op_d;        // op of the access in flight
  logic [1:0]  lane_q,      lane_d;      // addr[1:0] of the access in flight
  logic        mem_req_q,   mem_req_d;
  logic        mem_we_q,    mem_we_d;
  logic [31:0] mem_addr_q,  mem_addr_d;
  logic [3:0]  mem_be_q,    mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        busy_q,      busy_d;
  logic        done_q,      done_d;
  logic        misalign_q,  misalign_d;
  logic [31:0] load_data_q, load_data_d;

  // ---------------------------------------------------------------------------
  // Request decode (combinational view of the inputs at the start edge)
  // ---------------------------------------------------------------------------
  op_e         op_sel;
  logic        sel_misalign;
  logic        sel_store;
  logic [3:0]  sel_be;
  logic [31:0] sel_wdata;

  // The decoder is meant to be one-hot; if it is not, the fixed priority
  // below picks a single op so the unit never mixes two access types.
  always_comb begin
    if      (i_lw)  op_sel = OP_LW;
    else if (i_lh)  op_sel = OP_LH;
    else if (i_lhu) op_sel = OP_LHU;
    else if (i_lb)  op_sel = OP_LB;
    else if (i_lbu) op_sel = OP_LBU;
    else if (i_sw)  op_sel = OP_SW;
    else if (i_sh)  op_sel = OP_SH;
    else if (i_sb)  op_sel = OP_SB;
    else            op_sel = OP_NONE;
  end

  always_comb begin
    // NOTE: every output of a combinational block gets a default before the
    // case statement; a path that leaves one unassigned would infer a latch.
    sel_misalign = 1'b0;
    sel_store    = 1'b0;
    sel_be       = 4'b0000;
    sel_wdata    = wdata;
    case (op_sel)
      OP_LB, OP_LBU: begin
        sel_be = 4'b0001 << addr[1:0];
      end
      OP_SB: begin
        sel_store = 1'b1;
        sel_be    = 4'b0001 << addr[1:0];
        sel_wdata = {4{wdata[7:0]}};
      end
      OP_LH, OP_LHU: begin
        sel_misalign = addr[0];
        sel_be       = 4'b0011 << {addr[1], 1'b0};
      end
      OP_SH: begin
        sel_misalign = addr[0];
        sel_store    = 1'b1;
        sel_be       = 4'b0011 << {addr[1], 1'b0};
        sel_wdata    = {2{wdata[15:0]}};
      end
      OP_LW: begin
        sel_misalign = |addr[1:0];
        sel_be       = 4'b1111;
      end
      OP_SW: begin
        sel_misalign = |addr[1:0];
        sel_store    = 1'b1;
        sel_be       = 4'b1111;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load lane extraction from the read word, using the captured op and lane
  // ---------------------------------------------------------------------------
  logic [31:0] rd_shift;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic        ld_is_load;
  logic [31:0] ld_ext;

  assign rd_shift = bus.mem_rdata >> {lane_q, 3'b000};
  assign rd_byte  = rd_shift[7:0];
  assign rd_half  = lane_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

  always_comb begin
    ld_is_load = 1'b1;
    ld_ext     = bus.mem_rdata;
    case (op_q)
      OP_LB:   ld_ext = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU:  ld_ext = {24'h0, rd_byte};
      OP_LH:   ld_ext = {{16{rd_half[15]}}, rd_half};
      OP_LHU:  ld_ext = {16'h0, rd_half};
      OP_LW:   ld_ext = bus.mem_rdata;
      default: ld_is_load = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state and registered-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    lane_d      = lane_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    busy_d      = busy_q;
    load_data_d = load_data_q;
    done_d      = 1'b0;
    misalign_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d   = op_sel;
          lane_d = addr[1:0];
          busy_d = 1'b1;
          if (op_sel == OP_NONE || sel_misalign) begin
            // No bus access: finish next cycle, load_data untouched.
            state_d    = ST_FIN;
            done_d     = 1'b1;
            misalign_d = sel_misalign;
          end else begin
            state_d     = ST_REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = sel_store;
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_be_d    = sel_be;
            mem_wdata_d = sel_wdata;
          end
        end
      end

      ST_REQ: begin
        // Bus fields are only reloaded from IDLE, so they hold steady here
        // until the acknowledge.
        if (bus.mem_ack) begin
          state_d   = ST_FIN;
          done_d    = 1'b1;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          mem_be_d  = 4'b0000;
          if (ld_is_load) begin
            load_data_d = ld_ext;
          end
        end
      end

      ST_FIN: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples its _d value from before the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_NONE;
      lane_q      <= 2'b00;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= 32'h0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      misalign_q  <= 1'b0;
      load_data_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      lane_q      <= lane_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      misalign_q  <= misalign_d;
      load_data_q <= load_data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign misalign      = misalign_q;
  assign load_data     = load_data_q;

endmodule

// File: tb/tb_core_lsu.sv
// -----------------------------------------------------------------------------
// tb_core_lsu -- scoreboard bench for core_lsu.
//
// Each directed request pushes its expected bus transaction and its expected
// completion (cycle, misalign, load_data) into queues. Two monitors pop and
// compare whenever the DUT shows mem_req or done. A responder models the
// memory with a programmable number of wait cycles.
// -----------------------------------------------------------------------------
module tb_core_lsu;

  localparam logic [7:0] F_LB  = 8'h80;
  localparam logic [7:0] F_LH  = 8'h40;
  localparam logic [7:0] F_LW  = 8'h20;
  localparam logic [7:0] F_LBU = 8'h10;
  localparam logic [7:0] F_LHU = 8'h08;
  localparam logic [7:0] F_SB  = 8'h04;
  localparam logic [7:0] F_SH  = 8'h02;
  localparam logic [7:0] F_SW  = 8'h01;

  typedef struct {
    int          req_cyc;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } bus_exp_t;

  typedef struct {
    int          cyc;
    logic        mis;
    logic [31:0] ld;
  } done_exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  flags = 8'h00;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        busy, done, misalign;
  logic [31:0] load_data;

  core_lsu_if bus ();

  core_lsu dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .i_lb      (flags[7]),
    .i_lh      (flags[6]),
    .i_lw      (flags[5]),
    .i_lbu     (flags[4]),
    .i_lhu     (flags[3]),
    .i_sb      (flags[2]),
    .i_sh      (flags[1]),
    .i_sw      (flags[0]),
    .addr      (addr),
    .wdata     (wdata),
    .bus       (bus.master),
    .busy      (busy),
    .done      (done),
    .load_data (load_data),
    .misalign  (misalign)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  bus_exp_t  bus_q[$];
  done_exp_t done_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Memory responder: acks after wait_n wait cycles; spur_ack injects an
  // acknowledge regardless of mem_req.
  // ---------------------------------------------------------------------------
  int          wait_n = 0;
  int          wcnt = 0;
  logic [31:0] rdata_v = 32'h0;
  logic        spur_ack = 1'b0;

  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_req) begin
        if (wcnt == wait_n) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = rdata_v;
        end else begin
          bus.mem_ack = spur_ack;
          wcnt++;
        end
      end else begin
        bus.mem_ack = spur_ack;
        wcnt = 0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitors (sample on the falling edge)
  // ---------------------------------------------------------------------------
  logic prev_req = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (bus.mem_req) begin
        if (bus_q.size() == 0) begin
          check("bus_unexpected_req", 32'(bus.mem_addr), 32'hFFFF_FFFF);
        end else begin
          if (!prev_req) check("bus_req_cycle", 32'(cyc), 32'(bus_q[0].req_cyc));
          check("bus_we",   32'(bus.mem_we), 32'(bus_q[0].we));
          check("bus_addr", bus.mem_addr, bus_q[0].addr);
          check("bus_be",   32'(bus.mem_be), 32'(bus_q[0].be));
          if (bus_q[0].we) check("bus_wdata", bus.mem_wdata, bus_q[0].wd);
          if (bus.mem_ack) void'(bus_q.pop_front());
        end
      end
      prev_req = bus.mem_req;
    end
  end

  initial begin
    done_exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (done_q.size() == 0) begin
          check("done_unexpected", 32'(done), 32'h0);
        end else begin
          e = done_q.pop_front();
          check("done_cycle", 32'(cyc), 32'(e.cyc));
          check("misalign",   32'(misalign), 32'(e.mis));
          check("load_data",  load_data, e.ld);
          check("busy_at_done", 32'(busy), 32'h1);
        end
      end else if (misalign) begin
        check("misalign_without_done", 32'(misalign), 32'h0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Issue one request and wait for its done. lat is the done cycle relative to
  // the start cycle. extra pulses a store start while the access is pending.
  // ---------------------------------------------------------------------------
  task automatic issue(input logic [7:0] f, input logic [31:0] a, input logic [31:0] wd,
                       input int wn, input logic [31:0] rd,
                       input bit has_bus, input logic ewe, input logic [31:0] eaddr,
                       input logic [3:0] ebe, input logic [31:0] ewd,
                       input int lat, input logic emis, input logic [31:0] eld,
                       input bit extra);
    bus_exp_t  b;
    done_exp_t d;
    bit        got;
    @(posedge clk);
    #1;
    wait_n  = wn;
    rdata_v = rd;
    flags   = f;
    addr    = a;
    wdata   = wd;
    start   = 1'b1;
    if (has_bus) begin
      b.req_cyc = cyc + 1; b.we = ewe; b.addr = eaddr; b.be = ebe; b.wd = ewd;
      bus_q.push_back(b);
    end
    d.cyc = cyc + lat; d.mis = emis; d.ld = eld;
    done_q.push_back(d);
    @(posedge clk);
    #1;
    start = 1'b0;
    flags = 8'h00;
    if (extra) begin
      @(posedge clk);
      #1;
      start = 1'b1; flags = F_SW; addr = 32'h500; wdata = 32'h5555_AAAA;
      @(posedge clk);
      #1;
      start = 1'b0; flags = 8'h00;
    end
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("done_timeout", 32'(got), 32'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got=running want=finished");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  int d0;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mem_req",   32'(bus.mem_req), 32'h0);
    check("rst_mem_we",    32'(bus.mem_we), 32'h0);
    check("rst_mem_be",    32'(bus.mem_be), 32'h0);
    check("rst_mem_addr",  bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check("rst_busy",      32'(busy), 32'h0);
    check("rst_done",      32'(done), 32'h0);
    check("rst_misalign",  32'(misalign), 32'h0);
    check("rst_load_data", load_data, 32'h0);

    //     flags        addr          wdata         wn rdata         bus we addr          be       wdata         lat mis load          extra
    issue(F_LW,        32'h100, 32'h0,        2, 32'hDEADBEEF, 1, 0, 32'h100, 4'b1111, 32'h0,        4, 0, 32'hDEADBEEF, 0);
    issue(F_LB,        32'h103, 32'h0,        0, 32'h80FF7F01, 1, 0, 32'h100, 4'b1000, 32'h0,        2, 0, 32'hFFFFFF80, 0);
    issue(F_LBU,       32'h103, 32'h0,        0, 32'h80FF7F01, 1, 0, 32'h100, 4'b1000, 32'h0,        2, 0, 32'h00000080, 0);
    issue(F_SH,        32'h202, 32'h1234ABCD, 0, 32'h0,        1, 1, 32'h200, 4'b1100, 32'hABCDABCD, 2, 0, 32'h00000080, 0);
    issue(F_LW,        32'h101, 32'h0,        0, 32'h0,        0, 0, 32'h0,   4'b0000, 32'h0,        1, 1, 32'h00000080, 0);
    issue(F_LH,        32'h102, 32'h0,        1, 32'h80FF7F01, 1, 0, 32'h100, 4'b1100, 32'h0,        3, 0, 32'hFFFF80FF, 0);
    issue(F_LHU,       32'h100, 32'h0,        0, 32'h80FF7F01, 1, 0, 32'h100, 4'b0011, 32'h0,        2, 0, 32'h00007F01, 0);
    issue(F_SB,        32'h301, 32'h000000A5, 0, 32'h0,        1, 1, 32'h300, 4'b0010, 32'hA5A5A5A5, 2, 0, 32'h00007F01, 0);
    issue(F_SW,        32'h304, 32'hCAFEF00D, 1, 32'h0,        1, 1, 32'h304, 4'b1111, 32'hCAFEF00D, 3, 0, 32'h00007F01, 0);
    issue(F_SH,        32'h203, 32'h0,        0, 32'h0,        0, 0, 32'h0,   4'b0000, 32'h0,        1, 1, 32'h00007F01, 0);
    issue(F_LB,        32'h101, 32'h0,        0, 32'h80FF7F01, 1, 0, 32'h100, 4'b0010, 32'h0,        2, 0, 32'h0000007F, 0);
    issue(F_LW | F_LB, 32'h101, 32'h0,        0, 32'h0,        0, 0, 32'h0,   4'b0000, 32'h0,        1, 1, 32'h0000007F, 0);
    issue(F_LH | F_SW, 32'h102, 32'h0,        0, 32'h12345678, 1, 0, 32'h100, 4'b1100, 32'h0,        2, 0, 32'h00001234, 0);
    issue(8'h00,       32'h104, 32'h0,        0, 32'h0,        0, 0, 32'h0,   4'b0000, 32'h0,        1, 0, 32'h00001234, 0);

    // Start while busy: the store pulse must not produce a second access.
    d0 = done_cnt;
    issue(F_LW,        32'h400, 32'h0,        3, 32'h11111111, 1, 0, 32'h400, 4'b1111, 32'h0,        5, 0, 32'h11111111, 1);
    repeat (4) @(negedge clk);
    check("start_while_busy_ops", 32'(done_cnt - d0), 32'h1);

    // Reset in REQ coincident with mem_ack: access abandoned, no done.
    d0 = done_cnt;
    @(posedge clk);
    #1;
    wait_n = 2; rdata_v = 32'hFFFF_FFFF;
    flags = F_LW; addr = 32'h600; start = 1'b1;
    begin
      bus_exp_t b;
      b.req_cyc = cyc + 1; b.we = 1'b0; b.addr = 32'h600; b.be = 4'b1111; b.wd = 32'h0;
      bus_q.push_back(b);
    end
    @(posedge clk);
    #1 start = 1'b0; flags = 8'h00;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_req_mem_req",   32'(bus.mem_req), 32'h0);
    check("rst_req_busy",      32'(busy), 32'h0);
    check("rst_req_load_data", load_data, 32'h0);
    repeat (3) @(negedge clk);
    check("rst_req_no_done", 32'(done_cnt - d0), 32'h0);

    // Reset overrides a simultaneous start.
    @(posedge clk);
    #1 rst = 1'b1; start = 1'b1; flags = F_LW; addr = 32'h700;
    @(posedge clk);
    #1 rst = 1'b0; start = 1'b0; flags = 8'h00;
    @(negedge clk);
    check("rst_start_mem_req", 32'(bus.mem_req), 32'h0);
    check("rst_start_busy",    32'(busy), 32'h0);

    // Acknowledge outside REQ is ignored.
    d0 = done_cnt;
    @(posedge clk);
    #1 spur_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1 spur_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("spur_ack_no_done",   32'(done_cnt - d0), 32'h0);
    check("spur_ack_load_data", load_data, 32'h0);
    check("spur_ack_busy",      32'(busy), 32'h0);

    // Unit still works after all of the above.
    issue(F_LHU,       32'h802, 32'h0,        0, 32'hBEEF0000, 1, 0, 32'h800, 4'b1100, 32'h0,        2, 0, 32'h0000BEEF, 0);

    repeat (2) @(negedge clk);
    check("bus_queue_drained",  32'(bus_q.size()), 32'h0);
    check("done_queue_drained", 32'(done_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
